// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_ctrl_pkg : encodings shared by the multicycle MIPS control unit        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_R_WB     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_I_WB     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;

    localparam logic [1:0] c_SRCB_REG    = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM    = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] c_PC_ALU    = 2'b00;
    localparam logic [1:0] c_PC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       mem_err;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_alu_decoder : funct (R-type) or opcode (I-type) to alu_ctrl + valid    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       valid
);

    always_comb begin
        alu_ctrl = c_ALU_AND;
        valid    = 1'b0;
        if (opcode == c_OP_RTYPE) begin
            case (funct)
                c_FN_ADD: begin alu_ctrl = c_ALU_ADD; valid = 1'b1; end
                c_FN_SUB: begin alu_ctrl = c_ALU_SUB; valid = 1'b1; end
                c_FN_AND: begin alu_ctrl = c_ALU_AND; valid = 1'b1; end
                c_FN_OR:  begin alu_ctrl = c_ALU_OR;  valid = 1'b1; end
                c_FN_SLT: begin alu_ctrl = c_ALU_SLT; valid = 1'b1; end
                default:  ;
            endcase
        end else begin
            case (opcode)
                c_OP_ADDI: begin alu_ctrl = c_ALU_ADD; valid = 1'b1; end
                c_OP_SLTI: begin alu_ctrl = c_ALU_SLT; valid = 1'b1; end
                c_OP_ANDI: begin alu_ctrl = c_ALU_AND; valid = 1'b1; end
                c_OP_ORI:  begin alu_ctrl = c_ALU_OR;  valid = 1'b1; end
                default:   ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_multicycle_ctrl : main control FSM of the multicycle MIPS datapath     |
// | Optional perf counters: define MIPS_CTRL_PERF_EN.   Rev 1.0                 |
// +----------------------------------------------------------------------------+
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef MIPS_CTRL_PERF_EN
    ,parameter int PERF_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       mem_err
`ifdef MIPS_CTRL_PERF_EN
    ,output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] retired_cnt
`endif
);

    localparam int               CNT_W     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    ctrl_t            w_ctl;
    ctrl_t            w_out;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_mem_state;
    logic             w_timeout;
    logic [3:0]       w_dec_alu;
    logic             w_dec_valid;

    mips_alu_decoder u_alu_dec (
        .opcode   (opcode),
        .funct    (funct),
        .alu_ctrl (w_dec_alu),
        .valid    (w_dec_valid)
    );

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

    generate
        if (MEM_TIMEOUT > 0) begin : g_wdog_on
            assign w_timeout = w_mem_state && (r_wait_cnt == c_TIMEOUT);
        end else begin : g_wdog_off
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Any state change (including an abort back into FETCH) starts a fresh wait window.
    always_ff @(posedge clk) begin
        if (!rst_n || w_timeout || (w_next != r_state)) begin
            r_wait_cnt <= '0;
        end else if (w_mem_state && !mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        w_ctl  = '0;
        case (r_state)
            S_FETCH: begin
                w_ctl.mem_read  = 1'b1;
                w_ctl.alu_src_b = c_SRCB_FOUR;
                w_ctl.alu_ctrl  = c_ALU_ADD;
                w_ctl.pc_source = c_PC_ALU;
                if (w_timeout) begin
                    w_ctl.mem_read = 1'b0;
                    w_ctl.mem_err  = 1'b1;
                    w_next         = S_FETCH;
                end else if (mem_ready) begin
                    w_ctl.ir_write = 1'b1;
                    w_ctl.pc_write = 1'b1;
                    w_next         = S_DECODE;
                end
            end
            S_DECODE: begin
                w_ctl.alu_src_b = c_SRCB_IMM_SH;
                w_ctl.alu_ctrl  = c_ALU_ADD;
                case (opcode)
                    c_OP_RTYPE:                                   w_next = S_EXEC_R;
                    c_OP_LW, c_OP_SW:                             w_next = S_MEM_ADDR;
                    c_OP_BEQ:                                     w_next = S_BRANCH;
                    c_OP_J:                                       w_next = S_JUMP;
                    c_OP_ADDI, c_OP_SLTI, c_OP_ANDI, c_OP_ORI:    w_next = S_EXEC_I;
                    default: begin
                        w_ctl.illegal_op = 1'b1;
                        w_next           = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = c_SRCB_REG;
                w_ctl.alu_ctrl  = w_dec_alu;
                if (w_dec_valid) begin
                    w_next = S_R_WB;
                end else begin
                    w_ctl.illegal_op = 1'b1;
                    w_next           = S_FETCH;
                end
            end
            S_R_WB: begin
                w_ctl.reg_write = 1'b1;
                w_ctl.reg_dst   = 1'b1;
                w_next          = S_FETCH;
            end
            S_EXEC_I: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = c_SRCB_IMM;
                w_ctl.alu_ctrl  = w_dec_alu;
                w_next          = S_I_WB;
            end
            S_I_WB: begin
                w_ctl.reg_write = 1'b1;
                w_next          = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = c_SRCB_IMM;
                w_ctl.alu_ctrl  = c_ALU_ADD;
                w_next          = (opcode == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_ctl.mem_read = 1'b1;
                w_ctl.iord     = 1'b1;
                if (w_timeout) begin
                    w_ctl.mem_read = 1'b0;
                    w_ctl.mem_err  = 1'b1;
                    w_next         = S_FETCH;
                end else if (mem_ready) begin
                    w_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.mem_to_reg = 1'b1;
                w_next           = S_FETCH;
            end
            S_MEM_WR: begin
                w_ctl.mem_write = 1'b1;
                w_ctl.iord      = 1'b1;
                if (w_timeout) begin
                    w_ctl.mem_write = 1'b0;
                    w_ctl.mem_err   = 1'b1;
                    w_next          = S_FETCH;
                end else if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = c_SRCB_REG;
                w_ctl.alu_ctrl  = c_ALU_SUB;
                w_ctl.pc_source = c_PC_ALUOUT;
                w_ctl.pc_write  = zero;
                w_next          = S_FETCH;
            end
            S_JUMP: begin
                w_ctl.pc_source = c_PC_JUMP;
                w_ctl.pc_write  = 1'b1;
                w_next          = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Gating by rst_n keeps every enable low on the edge that abandons an instruction.
    assign w_out = rst_n ? w_ctl : '0;

    assign mem_read   = w_out.mem_read;
    assign mem_write  = w_out.mem_write;
    assign iord       = w_out.iord;
    assign ir_write   = w_out.ir_write;
    assign pc_write   = w_out.pc_write;
    assign reg_write  = w_out.reg_write;
    assign reg_dst    = w_out.reg_dst;
    assign mem_to_reg = w_out.mem_to_reg;
    assign alu_src_a  = w_out.alu_src_a;
    assign alu_src_b  = w_out.alu_src_b;
    assign alu_ctrl   = w_out.alu_ctrl;
    assign pc_source  = w_out.pc_source;
    assign illegal_op = w_out.illegal_op;
    assign mem_err    = w_out.mem_err;

`ifdef MIPS_CTRL_PERF_EN
    logic w_retire;

    always_comb begin
        case (r_state)
            S_R_WB, S_I_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP:
                w_retire = (w_next == S_FETCH) && !w_timeout;
            default:
                w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + 1'b1;
            retired_cnt <= retired_cnt + PERF_W'(w_retire);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mips_multicycle_ctrl : directed + randomized instruction-level checks    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_mips_multicycle_ctrl;

    localparam int TMO = 16;
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_read, mem_write, iord, ir_write, pc_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal_op, mem_err;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_ctrl;
`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .pc_source  (pc_source),
        .illegal_op (illegal_op),
        .mem_err    (mem_err)
`ifdef MIPS_CTRL_PERF_EN
        ,.cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       mem_err;
    } ctl_t;

    ctl_t obs;
    assign obs = {mem_read, mem_write, iord, ir_write, pc_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_source, illegal_op, mem_err};

    int   checks = 0;
    int   errors = 0;
    ctl_t m_all, m_noalu, m_abort;
    logic [5:0] nx_op, nx_fn;
    logic       nx_z;
    bit         load = 1'b0;
    logic [5:0] r_fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] i_ops [4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};

    // Reference model: instruction class and ALU code straight from the ISA tables.
    function automatic int kind(input logic [5:0] op);
        case (op)
            6'h00:                      return K_R;
            6'h08, 6'h0A, 6'h0C, 6'h0D: return K_I;
            6'h23:                      return K_LW;
            6'h2B:                      return K_SW;
            6'h04:                      return K_BEQ;
            6'h02:                      return K_J;
            default:                    return K_ILL;
        endcase
    endfunction

    function automatic logic [4:0] r_alu(input logic [5:0] fn);  // {ok, code}
        case (fn)
            6'h20:   return 5'b1_0010;
            6'h22:   return 5'b1_0110;
            6'h24:   return 5'b1_0000;
            6'h25:   return 5'b1_0001;
            6'h2A:   return 5'b1_0111;
            default: return 5'b0_0000;
        endcase
    endfunction

    function automatic logic [3:0] i_alu(input logic [5:0] op);
        case (op)
            6'h08:   return 4'b0010;
            6'h0A:   return 4'b0111;
            6'h0C:   return 4'b0000;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int rand_wait();
        return ($urandom_range(0, 15) == 0) ? TMO : int'($urandom_range(0, 3));
    endfunction

    task automatic step(input logic rdy, input ctl_t e, input ctl_t m, input string tag);
        @(negedge clk);
        if (load) begin
            opcode = nx_op; funct = nx_fn; zero = nx_z; load = 1'b0;
        end
        mem_ready = rdy;
        #1;
        checks++;
        assert ((obs & m) === (e & m)) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (mask %h)", tag, obs & m, e & m, m);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b1;
        #1;
        checks++;
        assert (obs === ctl_t'('0)) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, ctl_t'('0));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic mem_phase(input ctl_t base, input ctl_t fin, input int w, input string tag,
                             output bit aborted);
        ctl_t e;
        aborted = 1'b0;
        if (w >= TMO) begin
            for (int i = 0; i < TMO; i++) step(1'b0, base, m_all, tag);
            e = base; e.mem_read = 1'b0; e.mem_write = 1'b0; e.mem_err = 1'b1;
            step(1'b0, e, m_abort, {tag, "_abort"});
            aborted = 1'b1;
        end else begin
            for (int i = 0; i < w; i++) step(1'b0, base, m_all, tag);
            step(1'b1, fin, m_all, tag);
        end
    endtask

    function automatic ctl_t exp_fetch(input bit done);
        ctl_t e = '0;
        e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_ctrl = 4'b0010;
        e.ir_write = done; e.pc_write = done;
        return e;
    endfunction

    function automatic ctl_t exp_decode(input logic [5:0] op);
        ctl_t e = '0;
        e.alu_src_b = 2'b11; e.alu_ctrl = 4'b0010; e.illegal_op = (kind(op) == K_ILL);
        return e;
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw);
        ctl_t       e, f;
        bit         ab;
        logic [4:0] ra;
        int         w;
        nx_op = op; nx_fn = fn; nx_z = z; load = 1'b1;
        w = fw;
        do begin
            mem_phase(exp_fetch(1'b0), exp_fetch(1'b1), w, "fetch", ab);
            w = $urandom_range(0, 3);
        end while (ab);
        step(rnd(), exp_decode(op), m_all, "decode");
        e = '0;
        case (kind(op))
            K_R: begin
                ra = r_alu(fn);
                e.alu_src_a = 1'b1;
                if (ra[4]) begin
                    e.alu_ctrl = ra[3:0];
                    step(rnd(), e, m_all, "exec_r");
                    e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1;
                    step(rnd(), e, m_all, "r_wb");
                end else begin
                    e.illegal_op = 1'b1;
                    step(rnd(), e, m_noalu, "exec_r_bad_funct");
                end
            end
            K_I: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = i_alu(op);
                step(rnd(), e, m_all, "exec_i");
                e = '0; e.reg_write = 1'b1;
                step(rnd(), e, m_all, "i_wb");
            end
            K_LW, K_SW: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = 4'b0010;
                step(rnd(), e, m_all, "mem_addr");
                e = '0; e.iord = 1'b1;
                if (kind(op) == K_LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
                f = e;
                mem_phase(e, f, mw, (kind(op) == K_LW) ? "mem_rd" : "mem_wr", ab);
                if (kind(op) == K_LW && !ab) begin
                    e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                    step(rnd(), e, m_all, "mem_wb");
                end
            end
            K_BEQ: begin
                e.alu_src_a = 1'b1; e.alu_ctrl = 4'b0110; e.pc_source = 2'b01; e.pc_write = z;
                step(rnd(), e, m_all, "branch");
            end
            K_J: begin
                e.pc_source = 2'b10; e.pc_write = 1'b1;
                step(rnd(), e, m_all, "jump");
            end
            default: ;
        endcase
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation time limit reached before completion");
        $fatal(1, "time limit");
    end

    initial begin
        logic [5:0] op, fn;
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        m_all = '1;
        m_noalu = '1; m_noalu.alu_ctrl = '0;
        m_abort = '0;
        m_abort.mem_read = 1'b1; m_abort.mem_write = 1'b1; m_abort.ir_write = 1'b1;
        m_abort.pc_write = 1'b1; m_abort.reg_write = 1'b1; m_abort.illegal_op = 1'b1;
        m_abort.mem_err = 1'b1;
        repeat (2) @(posedge clk);
        do_reset("reset_outputs");

        run_instr(6'h00, 6'h20, 1'b0, 0, 0);     // add, 4 cycles
        run_instr(6'h23, 6'h00, 1'b0, 0, 2);     // lw with 2 wait cycles
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);     // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);     // beq not taken
        run_instr(6'h3F, 6'h20, 1'b0, 0, 0);     // illegal opcode
        run_instr(6'h00, 6'h20, 1'b0, TMO, 0);   // fetch timeout then refetch
        run_instr(6'h2B, 6'h00, 1'b0, 1, TMO);   // sw timeout
        run_instr(6'h23, 6'h00, 1'b0, 0, TMO);   // lw timeout
        run_instr(6'h00, 6'h3F, 1'b0, 0, 0);     // bad funct
        run_instr(6'h0D, 6'h00, 1'b0, 0, 0);
        run_instr(6'h02, 6'h00, 1'b0, 0, 0);

        // reset in the middle of an lw
        nx_op = 6'h23; nx_fn = 6'h00; nx_z = 1'b0; load = 1'b1;
        step(1'b1, exp_fetch(1'b1), m_all, "mid_fetch");
        step(1'b1, exp_decode(6'h23), m_all, "mid_decode");
        do_reset("reset_mid_instr");
        run_instr(6'h00, 6'h2A, 1'b0, 0, 0);

`ifdef MIPS_CTRL_PERF_EN
        do_reset("reset_perf");
        checks++;
        assert (cycle_cnt === 32'd0 && retired_cnt === 32'd0) else begin
            errors++;
            $error("FAIL perf_reset: observed %0d/%0d expected 0/0", cycle_cnt, retired_cnt);
        end
        run_instr(6'h02, 6'h00, 1'b0, 0, 0);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 0);
        run_instr(6'h08, 6'h00, 1'b0, 0, 0);
        @(posedge clk);
        #1;
        checks++;
        assert (retired_cnt === 32'd3) else begin
            errors++;
            $error("FAIL retired_cnt: observed %0d expected 3", retired_cnt);
        end
        checks++;
        assert (cycle_cnt === 32'd11) else begin
            errors++;
            $error("FAIL cycle_cnt: observed %0d expected 11", cycle_cnt);
        end
`endif

        for (int n = 0; n < 200; n++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 7))
                0:       begin op = 6'h00; fn = r_fns[$urandom_range(0, 4)]; end
                1:       op = 6'h00;
                2:       op = i_ops[$urandom_range(0, 3)];
                3:       op = 6'h23;
                4:       op = 6'h2B;
                5:       op = 6'h04;
                6:       op = 6'h02;
                default: begin
                    op = 6'($urandom);
                    while (kind(op) != K_ILL) op = 6'($urandom);
                end
            endcase
            run_instr(op, fn, rnd(), rand_wait(), rand_wait());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM sequencing the multicycle MIPS datapath: PC, IR, register file, ALU and unified instruction/data memory.
- Decodes opcode/funct, drives every datapath select and enable each cycle, and waits on the memory ready handshake.
- Sits beside the datapath inside the MIPS top; the top's clk feeds it directly.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting for mem_ready in a memory state before abort; 0 disables the watchdog.
- PERF_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_read / mem_write  out  1  memory access request, held until mem_ready
- iord  out  1  memory address: 0=PC, 1=ALUOut
- ir_write / pc_write / reg_write  out  1  register enables
- reg_dst  out  1  write register: 0=rt, 1=rd
- mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
- alu_src_a  out  1  0=PC, 1=regA
- alu_src_b  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op / mem_err  out  1  one-cycle error pulses

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. While rst_n=0 the state goes to FETCH and all outputs read 0. The first cycle after release is FETCH.
- Output timing: outputs decode combinationally from the state. Only pc_write, ir_write and the memory-state exits depend on mem_ready or zero in the same cycle.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_source=00.
  - Stay while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x23/0x2B -> MEM_ADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08/0x0A/0x0C/0x0D -> EXEC_I
  - anything else: illegal_op pulses, next state FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctrl from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. Next R_WB.
  - Unknown funct: illegal_op pulses, next FETCH, no write.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_ctrl per opcode: 0x08 ADD, 0x0A SLT, 0x0C AND, 0x0D OR. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1; wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEM_WR: mem_write=1, iord=1; wait for mem_ready, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_write=zero. Next FETCH.
- JUMP: pc_source=10, pc_write=1. Next FETCH.
- CPI: R/I-type 4, lw 5, sw 4, beq/j 3 with zero-wait memory. Each memory wait cycle adds 1.
- Watchdog: a counter clears on entry to FETCH/MEM_RD/MEM_WR and counts cycles spent in those states with mem_ready=0.
  - On reaching MEM_TIMEOUT: mem_err pulses, the request drops, next state FETCH.
  - No PC/IR/register write occurs on abort, so the same PC is refetched.
- mem_ready outside a memory state is ignored.
- Reset asserted mid-instruction abandons it; no enable is asserted on that edge.

Optional Feature:
- Macro: MIPS_CTRL_PERF_EN.
- With it: adds outputs cycle_cnt[PERF_W-1:0] and retired_cnt[PERF_W-1:0].
  - cycle_cnt increments every non-reset cycle.
  - retired_cnt increments on every transition into FETCH from R_WB, I_WB, MEM_WB, MEM_WR, BRANCH or JUMP. Illegal and aborted instructions are not counted.
  - Both clear on reset and wrap silently.
- Without it: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mips_ctrl_pkg: state encoding, opcode and funct constants, alu_ctrl codes, alu_src_b and pc_source codes.
- Sub-module mips_alu_decoder: combinational funct/opcode -> alu_ctrl plus a valid flag. Used in EXEC_R and EXEC_I.

Test Plan:
- Reset, then mem_ready tied 1, opcode 0x00 funct 0x20 -> FETCH, DECODE, EXEC_R(alu_ctrl=0010), R_WB(reg_write=1, reg_dst=1), back to FETCH at cycle 5.
- lw (0x23) with mem_ready low 2 cycles in MEM_RD -> mem_read held 3 cycles, iord=1; MEM_WB has mem_to_reg=1; total 7 cycles.
- beq (0x04) with zero=1 -> BRANCH pc_write=1, pc_source=01; with zero=0 -> pc_write=0.
- opcode 0x3F -> illegal_op pulses once in DECODE, next FETCH, no reg_write/mem_write.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> mem_err pulses after 16 cycles, ir_write/pc_write never asserted, refetch starts.
- With MIPS_CTRL_PERF_EN: run j, sw, addi (0x08), zero-wait -> retired_cnt=3, cycle_cnt=3+4+4=11.
